// File: rtl/int_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_sched_pkg
//  Description : Shared constants for the interrupt scheduler: Wishbone
//                register addresses, CTRL bit positions, FSM encoding and a
//                one-hot decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package int_sched_pkg;

    // Wishbone register addresses
    localparam logic [2:0] ADR_CTRL   = 3'd0;
    localparam logic [2:0] ADR_MASK   = 3'd1;
    localparam logic [2:0] ADR_PEND   = 3'd2;
    localparam logic [2:0] ADR_INSV   = 3'd3;
    localparam logic [2:0] ADR_HOLD   = 3'd4;
    localparam logic [2:0] ADR_SWTRIG = 3'd5;
    localparam logic [2:0] ADR_STAT   = 3'd6;

    // CTRL register bit positions
    localparam int CTRL_GEN  = 7;
    localparam int CTRL_ERR  = 1;
    localparam int CTRL_BUSY = 0;

    // Request FSM; two bits so the encoding drops straight into STAT[1:0]
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1
    } state_t;

    // Decode a 3-bit source index into an 8-bit one-hot vector
    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/int_sched_prio_enc8.sv
`default_nettype none
// ============================================================================
//  Module      : prio_enc8
//  Description : 8-bit priority encoder returning the highest set bit index,
//                with a valid flag when any bit is set.
//  Revision    : 1.0 - initial release
// ============================================================================
module prio_enc8 (
    input  logic [7:0] i_vec,
    output logic [2:0] o_idx,
    output logic       o_valid
);

    // Ascending scan: the last set bit seen is the highest one
    always_comb begin
        o_idx   = 3'd0;
        o_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i_vec[i]) begin
                o_idx   = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/int_sched.sv
`default_nettype none
// ============================================================================
//  Module      : int_sched
//  Description : Edge-triggered interrupt scheduler with request/ack/return
//                handshake, in-service tracking, post-return holdoff and an
//                8-bit Wishbone configuration port.
//                Build option INT_SCHED_NEST_EN: allow preemption by a
//                higher-index source while others are in service.
//  Revision    : 1.0 - initial release
// ============================================================================
module int_sched
    import int_sched_pkg::*;
#(
    parameter int HOLD_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] IRQ_ARR,
    output logic       INT_REQ,
    output logic [2:0] INT_ID,
    input  logic       INT_ACK,
    input  logic       INT_RET,
    input  logic [2:0] WB_ADRi,
    input  logic [7:0] WB_DATi,
    output logic [7:0] WB_DATo,
    input  logic       WB_WEi,
    input  logic       WB_CYCi,
    input  logic       WB_STBi,
    output logic       WB_ACKo
);

    logic [7:0]        r_irq_q;
    logic [7:0]        r_pend;
    logic [7:0]        r_mask;
    logic [7:0]        r_insv;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] r_cnt;
    logic              r_gen;
    logic              r_err;
    state_t            r_state;
    logic              r_int_req;
    logic [2:0]        r_int_id;

    logic       w_wr, w_wr_ctrl, w_wr_mask, w_wr_pend, w_wr_hold, w_wr_swtrig;
    logic [7:0] w_cand;
    logic [2:0] w_win_idx, w_top_idx;
    logic       w_win_vld, w_top_vld;
    logic       w_elig, w_go, w_ack_ok, w_ack_bad, w_withdraw;
    logic       w_ret_ok, w_ret_bad, w_cnt_act;
    logic [7:0] w_pend_set, w_pend_clr, w_insv_set, w_insv_clr;
    logic [7:0] w_hold_rd;
    logic [7:0] w_rdata;

    // Bus decode
    assign w_wr        = WB_CYCi & WB_STBi & WB_WEi;
    assign w_wr_ctrl   = w_wr && (WB_ADRi == ADR_CTRL);
    assign w_wr_mask   = w_wr && (WB_ADRi == ADR_MASK);
    assign w_wr_pend   = w_wr && (WB_ADRi == ADR_PEND);
    assign w_wr_hold   = w_wr && (WB_ADRi == ADR_HOLD);
    assign w_wr_swtrig = w_wr && (WB_ADRi == ADR_SWTRIG);

    assign w_cand = r_pend & r_mask;

    prio_enc8 u_win (.i_vec(w_cand), .o_idx(w_win_idx), .o_valid(w_win_vld));
    prio_enc8 u_top (.i_vec(r_insv), .o_idx(w_top_idx), .o_valid(w_top_vld));

`ifdef INT_SCHED_NEST_EN
    assign w_elig = !w_top_vld || (w_win_idx > w_top_idx);
`else
    assign w_elig = !w_top_vld;
`endif

    assign w_cnt_act  = (r_cnt != '0);
    assign w_go       = (r_state == S_IDLE) && r_gen && w_win_vld && !w_cnt_act && w_elig;
    assign w_ack_ok   = (r_state == S_REQ) && INT_ACK;
    assign w_ack_bad  = (r_state != S_REQ) && INT_ACK;
    // ACK takes precedence over a withdrawal in the same cycle
    assign w_withdraw = (r_state == S_REQ) && !INT_ACK && (!r_gen || !w_cand[r_int_id]);
    assign w_ret_ok   = INT_RET && w_top_vld;
    assign w_ret_bad  = INT_RET && !w_top_vld;

    assign w_pend_set = (IRQ_ARR & ~r_irq_q) | (w_wr_swtrig ? WB_DATi : 8'h00);
    assign w_pend_clr = (w_wr_pend ? WB_DATi : 8'h00) | (w_ack_ok ? onehot8(r_int_id) : 8'h00);
    assign w_insv_set = w_ack_ok ? onehot8(r_int_id) : 8'h00;
    assign w_insv_clr = w_ret_ok ? onehot8(w_top_idx) : 8'h00;

    // Request FSM; INT_ID is frozen for the whole REQ residency
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_int_req <= 1'b0;
            r_int_id  <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_state   <= S_REQ;
                        r_int_req <= 1'b1;
                        r_int_id  <= w_win_idx;
                    end
                end
                S_REQ: begin
                    if (INT_ACK || w_withdraw) begin
                        r_state   <= S_IDLE;
                        r_int_req <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_int_req <= 1'b0;
                end
            endcase
        end
    end

    // Edge capture, pending (set beats clear) and in-service bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_q <= 8'h00;
            r_pend  <= 8'h00;
            r_insv  <= 8'h00;
        end else begin
            r_irq_q <= IRQ_ARR;
            r_pend  <= (r_pend & ~w_pend_clr) | w_pend_set;
            r_insv  <= (r_insv & ~w_insv_clr) | w_insv_set;
        end
    end

    // Software-visible configuration and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gen  <= 1'b0;
            r_err  <= 1'b0;
            r_mask <= 8'h00;
            r_hold <= '0;
        end else begin
            if (w_wr_ctrl) r_gen  <= WB_DATi[CTRL_GEN];
            if (w_wr_mask) r_mask <= WB_DATi;
            if (w_wr_hold) r_hold <= WB_DATi[HOLD_W-1:0];
            if (w_ret_bad || w_ack_bad)
                r_err <= 1'b1;
            else if (w_wr_ctrl && WB_DATi[CTRL_ERR])
                r_err <= 1'b0;
        end
    end

    // Holdoff counter: reloaded on a valid return, saturates at zero
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_ret_ok)
            r_cnt <= r_hold;
        else if (w_cnt_act)
            r_cnt <= r_cnt - HOLD_W'(1);
    end

    assign w_hold_rd = 8'(r_hold);

    // Combinational read mux
    always_comb begin
        w_rdata = 8'h00;
        case (WB_ADRi)
            ADR_CTRL: w_rdata = {r_gen, 5'b00000, r_err, r_int_req};
            ADR_MASK: w_rdata = r_mask;
            ADR_PEND: w_rdata = r_pend;
            ADR_INSV: w_rdata = r_insv;
            ADR_HOLD: w_rdata = w_hold_rd;
            ADR_STAT: w_rdata = {1'b0, r_int_id, w_cnt_act, 1'b0, r_state};
            default:  w_rdata = 8'h00;
        endcase
    end

    assign WB_DATo = w_rdata;
    assign WB_ACKo = 1'b1;
    assign INT_REQ = r_int_req;
    assign INT_ID  = r_int_id;

endmodule
`default_nettype wire

// File: tb/tb_int_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_sched
//  Description : Self-checking bench for int_sched: directed scenarios
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_int_sched;
    import int_sched_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] IRQ_ARR = 8'h00;
    logic       INT_REQ;
    logic [2:0] INT_ID;
    logic       INT_ACK = 1'b0;
    logic       INT_RET = 1'b0;
    logic [2:0] WB_ADRi = 3'd0;
    logic [7:0] WB_DATi = 8'h00;
    logic [7:0] WB_DATo;
    logic       WB_WEi = 1'b0;
    logic       WB_CYCi = 1'b0;
    logic       WB_STBi = 1'b0;
    logic       WB_ACKo;

    int n_assert = 0;
    int n_fail   = 0;

    int_sched #(.HOLD_W(8)) dut (
        .clk(clk), .rst(rst), .IRQ_ARR(IRQ_ARR),
        .INT_REQ(INT_REQ), .INT_ID(INT_ID), .INT_ACK(INT_ACK), .INT_RET(INT_RET),
        .WB_ADRi(WB_ADRi), .WB_DATi(WB_DATi), .WB_DATo(WB_DATo),
        .WB_WEi(WB_WEi), .WB_CYCi(WB_CYCi), .WB_STBi(WB_STBi), .WB_ACKo(WB_ACKo)
    );

    always #10 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model state ----------------
    logic [7:0] m_pend, m_mask, m_insv, m_hold, m_cnt, m_irq_q;
    bit         m_gen, m_err, m_req;
    logic [2:0] m_id;

    function automatic int hi(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) if (v[i]) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_mask = 0; m_insv = 0; m_hold = 0; m_cnt = 0; m_irq_q = 0;
        m_gen = 0; m_err = 0; m_req = 0; m_id = 0;
    endtask

    // One clock of scheduler behaviour, from the register-level rules
    task automatic model_step(input logic [7:0] irq, input bit ack, input bit ret,
                              input bit wr, input logic [2:0] adr, input logic [7:0] dat);
        logic [7:0] cand, pset, pclr, nins, ncnt;
        int win, top;
        bit elig, nreq, nerr;
        logic [2:0] nid;
        cand = m_pend & m_mask;
        win  = hi(cand);
        top  = hi(m_insv);
`ifdef INT_SCHED_NEST_EN
        elig = (top < 0) || (win > top);
`else
        elig = (top < 0);
`endif
        pset = irq & ~m_irq_q; pclr = 0; nins = m_insv;
        nreq = m_req; nid = m_id; nerr = m_err; ncnt = m_cnt;
        if (wr && adr == ADR_SWTRIG) pset |= dat;
        if (wr && adr == ADR_PEND)   pclr |= dat;
        if (wr && adr == ADR_CTRL && dat[1]) nerr = 0;
        if (ret) begin
            if (top >= 0) begin nins[top] = 1'b0; ncnt = m_hold; end
            else nerr = 1;
        end else if (m_cnt != 0) ncnt = m_cnt - 8'd1;
        if (m_req) begin
            if (ack) begin nins[m_id] = 1'b1; pclr[m_id] = 1'b1; nreq = 0; end
            else if (!m_gen || !cand[m_id]) nreq = 0;
        end else begin
            if (ack) nerr = 1;
            if (m_gen && win >= 0 && m_cnt == 0 && elig) begin nreq = 1; nid = 3'(win); end
        end
        m_pend = (m_pend & ~pclr) | pset;
        m_insv = nins; m_req = nreq; m_id = nid; m_err = nerr; m_cnt = ncnt;
        if (wr && adr == ADR_CTRL) m_gen  = dat[7];
        if (wr && adr == ADR_MASK) m_mask = dat;
        if (wr && adr == ADR_HOLD) m_hold = dat;
        m_irq_q = irq;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chkrd(input string tag, input logic [2:0] a, input logic [7:0] exp);
        WB_WEi = 1'b0; WB_CYCi = 1'b0; WB_STBi = 1'b0; WB_ADRi = a;
        #1;
        chk(tag, 32'(WB_DATo), 32'(exp));
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [7:0] d);
        WB_ADRi = a; WB_DATi = d; WB_WEi = 1'b1; WB_CYCi = 1'b1; WB_STBi = 1'b1;
        tick();
        WB_WEi = 1'b0; WB_CYCi = 1'b0; WB_STBi = 1'b0;
    endtask

    task automatic ack_pulse(); INT_ACK = 1'b1; tick(); INT_ACK = 1'b0; endtask
    task automatic ret_pulse(); INT_RET = 1'b1; tick(); INT_RET = 1'b0; endtask

    logic [7:0] t_irq, t_dat;
    logic [2:0] t_adr;
    bit         t_ack, t_ret, t_wr, t_stb;

    initial begin
        // ---- reset state ----
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_req", 32'(INT_REQ), 0);
        chk("rst_id", 32'(INT_ID), 0);
        chkrd("rst_ctrl", ADR_CTRL, 8'h00);
        chkrd("rst_mask", ADR_MASK, 8'h00);
        chkrd("rst_pend", ADR_PEND, 8'h00);
        chkrd("rst_insv", ADR_INSV, 8'h00);
        chkrd("rst_hold", ADR_HOLD, 8'h00);
        chkrd("rst_stat", ADR_STAT, 8'h00);
        chkrd("rd_adr7", 3'd7, 8'h00);
        chk("wb_ack", 32'(WB_ACKo), 1);

        // ---- single source, two-cycle latency, ACK ----
        wb_wr(ADR_MASK, 8'h08);
        wb_wr(ADR_CTRL, 8'h80);
        IRQ_ARR = 8'h08;
        tick();
        chk("lat1_req", 32'(INT_REQ), 0);
        chkrd("lat1_pend", ADR_PEND, 8'h08);
        tick();
        chk("lat2_req", 32'(INT_REQ), 1);
        chk("lat2_id", 32'(INT_ID), 3);
        chkrd("busy", ADR_CTRL, 8'h81);
        chkrd("stat_req", ADR_STAT, 8'h31);
        ack_pulse();
        chk("ack_req", 32'(INT_REQ), 0);
        chkrd("ack_pend", ADR_PEND, 8'h00);
        chkrd("ack_insv", ADR_INSV, 8'h08);
        chkrd("ack_stat", ADR_STAT, 8'h30);
        ret_pulse();
        chkrd("ret_insv", ADR_INSV, 8'h00);
        chkrd("ret_noerr", ADR_CTRL, 8'h80);
        IRQ_ARR = 8'h00;

        // ---- simultaneous sources, highest index wins ----
        wb_wr(ADR_MASK, 8'hFF);
        IRQ_ARR = 8'h42;
        tick(); tick();
        chk("prio_req", 32'(INT_REQ), 1);
        chk("prio_id6", 32'(INT_ID), 6);
        ack_pulse();
        chkrd("prio_pend", ADR_PEND, 8'h02);
        chkrd("prio_insv", ADR_INSV, 8'h40);
        ret_pulse();
        chk("prio_ret_req", 32'(INT_REQ), 0);
        tick();
        chk("prio2_req", 32'(INT_REQ), 1);
        chk("prio_id1", 32'(INT_ID), 1);
        ack_pulse();
        ret_pulse();
        IRQ_ARR = 8'h00;

        // ---- holdoff after return ----
        wb_wr(ADR_HOLD, 8'h05);
        wb_wr(ADR_SWTRIG, 8'h04);
        tick();
        chk("hold_id2", 32'(INT_ID), 2);
        ack_pulse();
        wb_wr(ADR_SWTRIG, 8'h04);
        chkrd("hold_pend", ADR_PEND, 8'h04);
        tick();
        chk("insv_block", 32'(INT_REQ), 0);
        ret_pulse();
        chk("hold_k", 32'(INT_REQ), 0);
        chkrd("hold_stat", ADR_STAT, 8'h28);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("hold_wait", 32'(INT_REQ), 0);
        end
        tick();
        chk("hold_done", 32'(INT_REQ), 1);
        chk("hold_id", 32'(INT_ID), 2);
        ack_pulse();
        ret_pulse();
        wb_wr(ADR_HOLD, 8'h00);
        repeat (6) tick();

        // ---- withdrawal by W1C on PEND ----
        wb_wr(ADR_SWTRIG, 8'h10);
        tick();
        chk("wd_req", 32'(INT_REQ), 1);
        chk("wd_id", 32'(INT_ID), 4);
        wb_wr(ADR_PEND, 8'h10);
        tick();
        chk("wd_drop", 32'(INT_REQ), 0);
        chkrd("wd_stat", ADR_STAT, 8'h40);
        chkrd("wd_insv", ADR_INSV, 8'h00);
        chkrd("wd_pend", ADR_PEND, 8'h00);

        // ---- error flag ----
        ret_pulse();
        chkrd("err_ret", ADR_CTRL, 8'h82);
        chkrd("err_ret_hold", ADR_STAT, 8'h40);
        wb_wr(ADR_CTRL, 8'h82);
        chkrd("err_clr", ADR_CTRL, 8'h80);
        ack_pulse();
        chkrd("err_ack", ADR_CTRL, 8'h82);
        wb_wr(ADR_CTRL, 8'h82);
        chkrd("err_clr2", ADR_CTRL, 8'h80);

        // ---- nesting behaviour ----
        wb_wr(ADR_SWTRIG, 8'h04);
        tick();
        chk("nest_id2", 32'(INT_ID), 2);
        ack_pulse();
        chkrd("nest_insv", ADR_INSV, 8'h04);
        wb_wr(ADR_SWTRIG, 8'h20);
`ifdef INT_SCHED_NEST_EN
        tick();
        chk("nest_req", 32'(INT_REQ), 1);
        chk("nest_id5", 32'(INT_ID), 5);
        ack_pulse();
        chkrd("nest_insv2", ADR_INSV, 8'h24);
        ret_pulse();
        chkrd("nest_unw1", ADR_INSV, 8'h04);
        ret_pulse();
        chkrd("nest_unw2", ADR_INSV, 8'h00);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("nonest_block", 32'(INT_REQ), 0);
        end
        ret_pulse();
        chkrd("nonest_ret", ADR_INSV, 8'h00);
        tick();
        chk("nonest_req", 32'(INT_REQ), 1);
        chk("nonest_id5", 32'(INT_ID), 5);
        ack_pulse();
        chkrd("nonest_insv", ADR_INSV, 8'h20);
        ret_pulse();
`endif

        // ---- reset while requesting ----
        wb_wr(ADR_SWTRIG, 8'h81);
        tick();
        chk("mid_req", 32'(INT_REQ), 1);
        chk("mid_id", 32'(INT_ID), 7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req", 32'(INT_REQ), 0);
        chk("mid_rst_id", 32'(INT_ID), 0);
        chkrd("mid_rst_pend", ADR_PEND, 8'h00);
        chkrd("mid_rst_insv", ADR_INSV, 8'h00);
        chkrd("mid_rst_ctrl", ADR_CTRL, 8'h00);

        // ---- randomized traffic against the model ----
        model_reset();
        t_irq = 8'h00;
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) t_irq = 8'($urandom) & 8'($urandom);
            t_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 49) == 0);
            if (m_insv != 0)     t_ret = ($urandom_range(0, 5) == 0);
            else if (m_cnt == 0) t_ret = ($urandom_range(0, 59) == 0);
            else                 t_ret = 1'b0;
            t_wr  = ($urandom_range(0, 3) == 0);
            t_stb = ($urandom_range(0, 7) != 0);
            t_adr = 3'($urandom_range(0, 7));
            t_dat = 8'($urandom);
            if (t_adr == ADR_HOLD)   t_dat = t_dat & 8'h03;
            if (t_adr == ADR_SWTRIG) t_dat = t_dat & 8'($urandom);
            if (t_adr == ADR_CTRL) begin
                t_dat = {1'($urandom_range(0, 5) != 0), 5'b00000, 1'($urandom), 1'($urandom)};
                if (t_wr) begin t_ack = 1'b0; t_ret = 1'b0; end
            end
            IRQ_ARR = t_irq; INT_ACK = t_ack; INT_RET = t_ret;
            WB_ADRi = t_adr; WB_DATi = t_dat;
            WB_WEi = t_wr; WB_CYCi = t_wr; WB_STBi = t_wr & t_stb;
            tick();
            INT_ACK = 1'b0; INT_RET = 1'b0;
            model_step(t_irq, t_ack, t_ret, t_wr && t_stb, t_adr, t_dat);
            chk("rnd_req", 32'(INT_REQ), 32'(m_req));
            chk("rnd_id", 32'(INT_ID), 32'(m_id));
            chkrd("rnd_pend", ADR_PEND, m_pend);
            chkrd("rnd_insv", ADR_INSV, m_insv);
            chkrd("rnd_ctrl", ADR_CTRL, {m_gen, 5'b00000, m_err, m_req});
            chkrd("rnd_stat", ADR_STAT, {1'b0, m_id, (m_cnt != 0), 2'b00, m_req});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
